// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: bus widths, HALT opcode, FSM encoding.
package cpu_pkg;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: a branch redirect overrides a sequential load, otherwise hold.
module fetch_pc_gen
    import cpu_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic [AW-1:0] i_pc,
    input  logic          i_branch_en,
    input  logic [AW-1:0] i_branch_target,
    input  logic          i_load,
    output logic [AW-1:0] o_next_pc
);
    logic [AW-1:0] w_pc_inc;

    // Increment wraps naturally at 2^AW.
    assign w_pc_inc = i_pc + {{(AW-1){1'b0}}, 1'b1};

    always_comb begin
        o_next_pc = i_pc;
        if (i_branch_en) begin
            o_next_pc = i_branch_target;
        end else if (i_load) begin
            o_next_pc = w_pc_inc;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC drives the combinational ROM, the read word is registered
// toward decode with valid/ready, plus branch redirect and HALT stop/resume.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OPC_W-1:0]  HALT_OP  = OP_HALT
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               resume,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);
    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [ADDR_W-1:0]  r_out_pc;
    logic               w_load;
    logic               w_is_halt;

    assign imem_addr = r_pc;
    assign w_is_halt = (imem_instr[INSTR_W-1 -: OPC_W] == HALT_OP);
    // A redirect squashes the fetch, so a branch cycle never loads.
    assign w_load    = (r_state == RUN) && (!r_out_valid || out_ready) && !branch_en;

    fetch_pc_gen #(.AW(ADDR_W)) u_pc_gen (
        .i_pc            (r_pc),
        .i_branch_en     (branch_en),
        .i_branch_target (branch_target),
        .i_load          (w_load),
        .o_next_pc       (w_pc_next)
    );

    always_comb begin
        w_state_next = r_state;
        if (branch_en) begin
            w_state_next = RUN;
        end else if (w_load && w_is_halt) begin
            w_state_next = HALT;
        end else if (r_state == HALT && resume) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Output register toward decode; holds untouched while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else if (branch_en) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_instr <= imem_instr;
            r_out_pc    <= r_pc;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign halted    = (r_state == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural 256x16 ROM.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        branch_en = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        resume = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;

    logic [15:0] rom [256];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr];

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .resume        (resume),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                           input logic [7:0] pc, input logic [7:0] addr, input logic h);
        check({tag, ".valid"},  32'(out_valid), 32'(v));
        if (v) begin
            check({tag, ".instr"}, 32'(out_instr), 32'(ins));
            check({tag, ".pc"},    32'(out_pc),    32'(pc));
        end
        check({tag, ".addr"},   32'(imem_addr), 32'(addr));
        check({tag, ".halted"}, 32'(halted),    32'(h));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".valid"},  32'(out_valid), 32'h0);
        check({tag, ".instr"},  32'(out_instr), 32'h0);
        check({tag, ".pc"},     32'(out_pc),    32'h0);
        check({tag, ".addr"},   32'(imem_addr), 32'h0);
        check({tag, ".halted"}, 32'(halted),    32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
        rom[5] = 16'hF000;

        // Reset state and straight-line fetch
        #1 rst = 1'b1;
        #1 chk_reset("rst0");
        #1 rst = 1'b0;
        tick(); chk_out("seq0", 1'b1, 16'h1000, 8'h00, 8'h01, 1'b0);
        tick(); chk_out("seq1", 1'b1, 16'h1001, 8'h01, 8'h02, 1'b0);
        tick(); chk_out("seq2", 1'b1, 16'h1002, 8'h02, 8'h03, 1'b0);
        tick(); chk_out("seq3", 1'b1, 16'h1003, 8'h03, 8'h04, 1'b0);

        // Back-pressure stall on 1001
        rst = 1'b1;
        #1 chk_reset("rst1");
        rst = 1'b0;
        tick(); chk_out("b0", 1'b1, 16'h1000, 8'h00, 8'h01, 1'b0);
        tick(); chk_out("b1", 1'b1, 16'h1001, 8'h01, 8'h02, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("stall", 1'b1, 16'h1001, 8'h01, 8'h02, 1'b0);
        end
        out_ready = 1'b1;
        tick(); chk_out("unstall", 1'b1, 16'h1002, 8'h02, 8'h03, 1'b0);

        // Branch while stalled on 1002 squashes it
        out_ready = 1'b0;
        tick(); chk_out("stall2", 1'b1, 16'h1002, 8'h02, 8'h03, 1'b0);
        branch_en = 1'b1; branch_target = 8'h40;
        tick(); chk_out("br_bubble", 1'b0, 16'h0, 8'h0, 8'h40, 1'b0);
        branch_en = 1'b0; out_ready = 1'b1;
        tick(); chk_out("br_tgt", 1'b1, 16'h1040, 8'h40, 8'h41, 1'b0);

        // HALT opcode at 05, drain, idle, resume
        branch_en = 1'b1; branch_target = 8'h04;
        tick(); chk_out("h_br", 1'b0, 16'h0, 8'h0, 8'h04, 1'b0);
        branch_en = 1'b0;
        tick(); chk_out("h_04", 1'b1, 16'h1004, 8'h04, 8'h05, 1'b0);
        tick(); chk_out("h_op", 1'b1, 16'hF000, 8'h05, 8'h06, 1'b1);
        tick(); chk_out("h_drain", 1'b0, 16'h0, 8'h0, 8'h06, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(); chk_out("h_idle", 1'b0, 16'h0, 8'h0, 8'h06, 1'b1);
        end
        resume = 1'b1;
        tick(); chk_out("h_resume", 1'b0, 16'h0, 8'h0, 8'h06, 1'b0);
        resume = 1'b0;
        tick(); chk_out("h_06", 1'b1, 16'h1006, 8'h06, 8'h07, 1'b0);
        resume = 1'b1;
        tick(); chk_out("run_resume", 1'b1, 16'h1007, 8'h07, 8'h08, 1'b0);
        resume = 1'b0;

        // PC wrap FF -> 00
        branch_en = 1'b1; branch_target = 8'hFE;
        tick(); chk_out("w_br", 1'b0, 16'h0, 8'h0, 8'hFE, 1'b0);
        branch_en = 1'b0;
        tick(); chk_out("w_fe", 1'b1, 16'h10FE, 8'hFE, 8'hFF, 1'b0);
        tick(); chk_out("w_ff", 1'b1, 16'h10FF, 8'hFF, 8'h00, 1'b0);
        tick(); chk_out("w_00", 1'b1, 16'h1000, 8'h00, 8'h01, 1'b0);

        // Async reset while halted with a pending output
        branch_en = 1'b1; branch_target = 8'h05;
        tick(); chk_out("r_br", 1'b0, 16'h0, 8'h0, 8'h05, 1'b0);
        branch_en = 1'b0;
        tick(); chk_out("r_halt", 1'b1, 16'hF000, 8'h05, 8'h06, 1'b1);
        out_ready = 1'b0;
        tick(); chk_out("r_hold", 1'b1, 16'hF000, 8'h05, 8'h06, 1'b1);
        rst = 1'b1;
        #1 chk_reset("rst_halt");
        rst = 1'b0; out_ready = 1'b1;
        tick(); chk_out("r_after", 1'b1, 16'h1000, 8'h00, 8'h01, 1'b0);

        // Async reset during a branch cycle
        branch_en = 1'b1; branch_target = 8'h40;
        rst = 1'b1;
        #1 chk_reset("rst_br");
        tick(); chk_reset("rst_br_edge");
        rst = 1'b0; branch_en = 1'b0;
        tick(); chk_out("rb_after", 1'b1, 16'h1000, 8'h00, 8'h01, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
